// File: rtl/video_stream_gen.sv
// Test-pattern video stream generator with line/frame markers.
// Define VIDEO_STREAM_GEN_FRAME_SHIFT_EN to scroll the pattern by one each frame.
module video_stream_gen #(
  parameter int PX_WIDTH        = 12,
  parameter int PX_PER_CLK      = 4,
  parameter int MAX_LINE_SIZE   = 4112,
  parameter int MAX_FRAME_LINES = 4096,
  parameter int HBLANK          = 16,
  parameter int VBLANK          = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 stop_i,
  input  logic [$clog2(MAX_LINE_SIZE+1)-1:0]   line_size_i,
  input  logic [$clog2(MAX_FRAME_LINES+1)-1:0] frame_lines_i,
  output logic [PX_PER_CLK*PX_WIDTH-1:0]       px_data_o,
  output logic [PX_PER_CLK-1:0]                px_data_val_o,
  output logic                                 line_start_o,
  output logic                                 line_end_o,
  output logic                                 frame_start_o,
  output logic                                 frame_end_o,
  output logic                                 busy_o
);
  localparam int LW   = $clog2(MAX_LINE_SIZE+1);
  localparam int FW   = $clog2(MAX_FRAME_LINES+1);
  localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BW   = $clog2(BMAX+1);
  localparam int DW   = PX_PER_CLK*PX_WIDTH;

  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [FW-1:0] F_ONE  = FW'(1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [LW-1:0] L_MAX  = LW'(MAX_LINE_SIZE);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FRAME_LINES);
  localparam logic [BW-1:0] H_LAST = BW'(HBLANK-1);
  localparam logic [BW-1:0] V_LAST = BW'(VBLANK-1);

  typedef enum logic [1:0] {
    ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_VBLANK
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    word_q, word_d;
  logic [LW-1:0]    lsz_q, lsz_d;
  logic [LW-1:0]    nw_q, nw_d;
  logic [FW-1:0]    line_q, line_d;
  logic [FW-1:0]    fl_q, fl_d;
  logic [BW-1:0]    blank_q, blank_d;
  logic             stop_q, stop_d;
  logic [DW-1:0]    data_q, data_d;
  logic [PX_PER_CLK-1:0] val_q, val_d;
  logic             ls_q, ls_d, le_q, le_d;
  logic             fs_q, fs_d, fe_q, fe_d;

  logic             geo_ok, load, act, last_w, last_l;
  logic [LW:0]      nw_sum;
  logic [LW-1:0]    rem;
  logic [31:0]      shift;
  logic [PX_WIDTH-1:0] pix;

`ifdef VIDEO_STREAM_GEN_FRAME_SHIFT_EN
  logic [7:0] fcnt_q, fcnt_d;
  assign fcnt_d = fcnt_q + 8'(fe_d);
  assign shift  = 32'(fcnt_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end
`else
  assign shift = '0;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    line_d  = line_q;
    blank_d = blank_q;
    lsz_d   = lsz_q;
    fl_d    = fl_q;
    nw_d    = nw_q;
    load    = 1'b0;
    stop_d  = stop_q | ((state_q != ST_IDLE) & stop_i);
    geo_ok  = (line_size_i != '0) && (line_size_i <= L_MAX) &&
              (frame_lines_i != '0) && (frame_lines_i <= F_MAX);
    nw_sum  = {1'b0, line_size_i} + (LW+1)'(PX_PER_CLK-1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i && geo_ok) begin
          state_d = ST_ACTIVE;
          load    = 1'b1;
          stop_d  = stop_i;
        end
      end
      ST_ACTIVE: begin
        if (word_q == nw_q - L_ONE) begin
          blank_d = '0;
          state_d = (line_q == fl_q - F_ONE) ? ST_VBLANK : ST_HBLANK;
        end else begin
          word_d = word_q + L_ONE;
        end
      end
      ST_HBLANK: begin
        if (blank_q == H_LAST) begin
          state_d = ST_ACTIVE;
          word_d  = '0;
          line_d  = line_q + F_ONE;
        end else begin
          blank_d = blank_q + B_ONE;
        end
      end
      ST_VBLANK: begin
        if (blank_q == V_LAST) begin
          if (stop_d || !geo_ok) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
            load    = 1'b1;
          end
        end else begin
          blank_d = blank_q + B_ONE;
        end
      end
    endcase

    if (load) begin
      lsz_d  = line_size_i;
      fl_d   = frame_lines_i;
      nw_d   = LW'(nw_sum / (LW+1)'(PX_PER_CLK));
      word_d = '0;
      line_d = '0;
    end
    if (state_d == ST_IDLE) stop_d = 1'b0;
  end

  // Outputs are computed from the next state so they register in step with it
  always_comb begin
    act    = (state_d == ST_ACTIVE);
    last_w = (word_d == nw_d - L_ONE);
    last_l = (line_d == fl_d - F_ONE);
    rem    = (lsz_d - L_ONE) % LW'(PX_PER_CLK);
    data_d = '0;
    val_d  = '0;
    pix    = '0;
    for (int k = 0; k < PX_PER_CLK; k++) begin
      pix = PX_WIDTH'(32'(word_d) * 32'(PX_PER_CLK) + 32'(k) +
                      32'(line_d) + shift);
      if (act && (!last_w || k <= int'(rem))) begin
        data_d[k*PX_WIDTH +: PX_WIDTH] = pix;
        val_d[k] = 1'b1;
      end
    end
    ls_d = act & (word_d == '0);
    le_d = act & last_w;
    fs_d = ls_d & (line_d == '0);
    fe_d = le_d & last_l;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      line_q  <= '0;
      blank_q <= '0;
      lsz_q   <= '0;
      fl_q    <= '0;
      nw_q    <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      val_q   <= '0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      line_q  <= line_d;
      blank_q <= blank_d;
      lsz_q   <= lsz_d;
      fl_q    <= fl_d;
      nw_q    <= nw_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      val_q   <= val_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
    end
  end

  assign px_data_o     = data_q;
  assign px_data_val_o = val_q;
  assign line_start_o  = ls_q;
  assign line_end_o    = le_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/video_stream_gen.md
VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

Interface
REQ-001 SHALL have parameter PX_WIDTH, default 12, bits per pixel.
REQ-002 SHALL have parameter PX_PER_CLK, default 4, pixels per word.
REQ-003 SHALL have parameter MAX_LINE_SIZE, default 4112, max pixels per line.
REQ-004 SHALL have parameter MAX_FRAME_LINES, default 4096, max lines per frame.
REQ-005 SHALL have parameter HBLANK, default 16, idle clocks between lines (>=1).
REQ-006 SHALL have parameter VBLANK, default 64, idle clocks between frames (>=1).
REQ-007 SHALL have port clk_i  in  1  clock; all logic on rising edge.
REQ-008 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-009 SHALL have ports start_i / stop_i  in  1 each  begin continuous generation / finish current frame and idle.
REQ-010 SHALL have ports line_size_i  in  $clog2(MAX_LINE_SIZE+1)  and frame_lines_i  in  $clog2(MAX_FRAME_LINES+1)  frame geometry.
REQ-011 SHALL have port px_data_o  out  PX_PER_CLK x PX_WIDTH  pixel word, lane 0 = lowest column.
REQ-012 SHALL have port px_data_val_o  out  PX_PER_CLK  per-lane valid.
REQ-013 SHALL have ports line_start_o, line_end_o, frame_start_o, frame_end_o  out  1 each  stream markers.
REQ-014 SHALL have port busy_o  out  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACTIVE, HBLANK, VBLANK.
REQ-016 IDLE -> ACTIVE when start_i=1 and both geometry inputs nonzero and within max; otherwise start_i ignored.
REQ-017 Geometry SHALL be latched on IDLE->ACTIVE and VBLANK->ACTIVE only; changes mid-frame have no effect.
REQ-018 First word SHALL appear on outputs the cycle after start_i is sampled; all outputs registered.
REQ-019 ACTIVE SHALL emit ceil(line_size/PX_PER_CLK) consecutive words per line, no gaps.
REQ-020 Last word of line SHALL assert only lanes 0..((line_size-1) mod PX_PER_CLK); all other words all lanes.
REQ-021 Lane k of word w on line y SHALL carry (w*PX_PER_CLK + k + y) mod 2^PX_WIDTH; invalid lanes 0.
REQ-022 line_start_o on first word of each line; line_end_o on last word (both same cycle if one word).
REQ-023 frame_start_o with line_start_o of line 0; frame_end_o with line_end_o of last line.
REQ-024 After non-final line: HBLANK for exactly HBLANK clocks, then ACTIVE; after final line: VBLANK for VBLANK clocks.
REQ-025 VBLANK end: ACTIVE (new frame) unless stop pending, then IDLE.
REQ-026 stop_i sampled in any non-IDLE state SHALL set a stop-pending flag; frame completes intact; flag cleared on entering IDLE.
REQ-027 start_i and stop_i both high in IDLE: start wins, stop pending set, exactly one frame generated.
REQ-028 Outside ACTIVE, px_data_val_o, all markers and px_data_o SHALL be 0.

Reset
REQ-029 rst_i SHALL force IDLE, all outputs 0, counters and stop flag cleared, next cycle; mid-frame reset truncates frame with no frame_end_o.

Configuration
REQ-030 Macro VIDEO_STREAM_GEN_FRAME_SHIFT_EN defined: 8-bit frame counter (reset 0, wraps, increments at each frame_end_o) added to REQ-021 pixel value, giving moving pattern.
REQ-031 Macro undefined: no frame counter; pattern identical every frame per REQ-021.

Verification
REQ-032 line_size=8, frame_lines=2, PX_PER_CLK=4, start pulse -> words (0,1,2,3),(4,5,6,7) line 0, (1..4),(5..8) line 1; 16 HBLANK clocks between; frame_end on cycle 4 of active data.
REQ-033 line_size=5 -> 2 words/line, last word px_data_val_o=4'b0001, lanes 1-3 data 0.
REQ-034 line_size=3, frame_lines=1 -> single word val=4'b0111 with line_start, line_end, frame_start, frame_end all high same cycle.
REQ-035 start, stop pulsed mid line 1 of 3-line frame -> lines 1-2 complete, VBLANK, busy_o falls, no further data.
REQ-036 rst_i asserted mid-line -> next cycle all outputs 0, busy_o=0; new start_i produces frame_start_o with pixel 0 value 0.
REQ-037 line_size_i=0 with start_i -> busy_o stays 0, no output; with FRAME_SHIFT_EN, second frame pixel 0 = 1.
